// File: rtl/ula_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ula_arbiter
// Purpose  : Two-requester round-robin arbiter that sequences commands onto a
//            single shared combinational 6-bit ULA. Each requester owns one
//            response slot holding result and flags until it is consumed.
// Revision : 1.0 - initial release
// ============================================================================
module ula_arbiter #(
    parameter logic PRIO_RESET = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    // Requester 0
    input  logic       req_valid_0,
    output logic       req_ready_0,
    input  logic [5:0] req_a_0,
    input  logic [5:0] req_b_0,
    input  logic [3:0] req_s_0,
    output logic       rsp_valid_0,
    input  logic       rsp_ready_0,
    output logic [5:0] rsp_o_0,
    output logic       rsp_c_0,
    output logic       rsp_z_0,
    // Requester 1
    input  logic       req_valid_1,
    output logic       req_ready_1,
    input  logic [5:0] req_a_1,
    input  logic [5:0] req_b_1,
    input  logic [3:0] req_s_1,
    output logic       rsp_valid_1,
    input  logic       rsp_ready_1,
    output logic [5:0] rsp_o_1,
    output logic       rsp_c_1,
    output logic       rsp_z_1,
    // Shared ULA
    output logic [5:0] ula_a,
    output logic [5:0] ula_b,
    output logic [3:0] ula_s,
    output logic       ula_r,
    input  logic [5:0] ula_o,
    input  logic       ula_c,
    input  logic       ula_z
);

    // Op stage: the command currently driving the ULA
    logic       r_op_v;
    logic       r_op_id;
    logic [5:0] r_op_a;
    logic [5:0] r_op_b;
    logic [3:0] r_op_s;
    // Last requester granted; the other one wins the next contended grant
    logic       r_last;

    logic       w_elig_0;
    logic       w_elig_1;
    logic       w_grant_0;
    logic       w_grant_1;

    // Eligibility and round-robin grant; one outstanding command per requester
    always_comb begin
        w_elig_0  = req_valid_0 && !rsp_valid_0 && !(r_op_v && (r_op_id == 1'b0));
        w_elig_1  = req_valid_1 && !rsp_valid_1 && !(r_op_v && (r_op_id == 1'b1));
        w_grant_0 = w_elig_0 && (!w_elig_1 || (r_last == 1'b1));
        w_grant_1 = w_elig_1 && (!w_elig_0 || (r_last == 1'b0));
    end

    assign req_ready_0 = w_grant_0;
    assign req_ready_1 = w_grant_1;

    // Op stage load on accept; otherwise the stage empties after one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_v  <= 1'b0;
            r_op_id <= 1'b0;
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_op_s  <= '0;
            r_last  <= ~PRIO_RESET;
        end else if (w_grant_0) begin
            r_op_v  <= 1'b1;
            r_op_id <= 1'b0;
            r_op_a  <= req_a_0;
            r_op_b  <= req_b_0;
            r_op_s  <= req_s_0;
            r_last  <= 1'b0;
        end else if (w_grant_1) begin
            r_op_v  <= 1'b1;
            r_op_id <= 1'b1;
            r_op_a  <= req_a_1;
            r_op_b  <= req_b_1;
            r_op_s  <= req_s_1;
            r_last  <= 1'b1;
        end else begin
            r_op_v  <= 1'b0;
        end
    end

    // Response slots: capture ULA outputs at the end of an op, clear on consume.
    // Eligibility keeps a slot empty while its own op executes, so capture and
    // consume never collide on the same slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_0 <= 1'b0;
            rsp_o_0     <= '0;
            rsp_c_0     <= 1'b0;
            rsp_z_0     <= 1'b0;
            rsp_valid_1 <= 1'b0;
            rsp_o_1     <= '0;
            rsp_c_1     <= 1'b0;
            rsp_z_1     <= 1'b0;
        end else begin
            if (r_op_v && (r_op_id == 1'b0)) begin
                rsp_valid_0 <= 1'b1;
                rsp_o_0     <= ula_o;
                rsp_c_0     <= ula_c;
                rsp_z_0     <= ula_z;
            end else if (rsp_ready_0) begin
                rsp_valid_0 <= 1'b0;
            end
            if (r_op_v && (r_op_id == 1'b1)) begin
                rsp_valid_1 <= 1'b1;
                rsp_o_1     <= ula_o;
                rsp_c_1     <= ula_c;
                rsp_z_1     <= ula_z;
            end else if (rsp_ready_1) begin
                rsp_valid_1 <= 1'b0;
            end
        end
    end

    // ULA is driven only while an op is in flight and held in reset otherwise
    assign ula_a = r_op_v ? r_op_a : 6'd0;
    assign ula_b = r_op_v ? r_op_b : 6'd0;
    assign ula_s = r_op_v ? r_op_s : 4'd0;
    assign ula_r = !r_op_v;

endmodule
`default_nettype wire
